dct_sequencer: RTL and testbench

Control and feed engine for the MFCC cepstral DCT stage. It reads log-mel energies from the mel buffer and generates DCT coefficient ROM addresses. It drives regdct_out, muldct_en, addsubdct_en and addsubdct_new into the cepstral multiply-accumulate block, then captures each finished addsubdct_out as one cepstral coefficient. It sits between the log-energy buffer and the cepstral MAC, and initiates every transaction the MAC consumes.

---
 rtl/dct_sequencer_pkg.sv | 24 ++
 rtl/dct_term_pipe.sv | 54 +++++
 rtl/dct_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dct_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_sequencer_pkg.sv
// rtl/dct_sequencer_pkg.sv - shared MFCC cepstral DCT constants and FSM encoding
package dct_sequencer_pkg;

    localparam int NUM_FILT   = 26;
    localparam int NUM_CEP    = 13;
    localparam int MEL_AW     = 5;
    localparam int CDCT_AW    = 9;
    localparam int CEP_IW     = 4;

    // Cycles from term issue (mel_addr) to the cepstral capture strobe.
    localparam int PIPE_DEPTH = 5;

    // Stage index = cycles after issue at which a term's flag is consumed.
    localparam int STG_MUL    = 2;
    localparam int STG_ACC    = 3;
    localparam int STG_CAP    = PIPE_DEPTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dct_term_pipe.sv
// rtl/dct_term_pipe.sv - per-term valid/first/last/k shift register driving the MAC enables
module dct_term_pipe
    import dct_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [CEP_IW-1:0] i_k,
    output logic              o_mel_valid,
    output logic              o_mul_en,
    output logic              o_acc_en,
    output logic              o_acc_new,
    output logic              o_cap,
    output logic [CEP_IW-1:0] o_cap_k,
    output logic              o_empty
);

    // Bit s holds the term issued s cycles ago; first/last are pre-gated by valid.
    logic [STG_CAP:1]  r_v;
    logic [STG_ACC:1]  r_first;
    logic [STG_CAP:1]  r_last;
    logic [CEP_IW-1:0] r_k [1:STG_CAP];

    // Advance every term one stage per cycle; bubbles enter as zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_first <= '0;
            r_last  <= '0;
            for (int s = 1; s <= STG_CAP; s++) begin
                r_k[s] <= '0;
            end
        end else begin
            r_v     <= {r_v[STG_CAP-1:1], i_issue};
            r_first <= {r_first[STG_ACC-1:1], i_issue & i_first};
            r_last  <= {r_last[STG_CAP-1:1], i_issue & i_last};
            r_k[1]  <= i_k;
            for (int s = 2; s <= STG_CAP; s++) begin
                r_k[s] <= r_k[s-1];
            end
        end
    end

    assign o_mel_valid = r_v[1];
    assign o_mul_en    = r_v[STG_MUL];
    assign o_acc_en    = r_v[STG_ACC];
    assign o_acc_new   = r_first[STG_ACC];
    assign o_cap       = r_last[STG_CAP];
    assign o_cap_k     = r_k[STG_CAP];
    assign o_empty     = ~|r_v;

endmodule

// File: rtl/dct_sequencer.sv
// rtl/dct_sequencer.sv - cepstral DCT sequencer: mel/ROM addressing, MAC control, coefficient capture
module dct_sequencer
    import dct_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    output logic [MEL_AW-1:0]  o_mel_addr,
    input  logic [15:0]        i_mel_rdata,
    output logic [CDCT_AW-1:0] o_cdct_addr,
    output logic [15:0]        o_regdct_out,
    output logic               o_muldct_en,
    output logic               o_addsubdct_en,
    output logic               o_addsubdct_new,
    input  logic [15:0]        i_addsubdct_out,
    output logic [15:0]        o_cep_data,
    output logic [CEP_IW-1:0]  o_cep_idx,
    output logic               o_cep_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [MEL_AW-1:0] J_LAST = MEL_AW'(NUM_FILT - 1);
    localparam logic [CEP_IW-1:0] K_LAST = CEP_IW'(NUM_CEP - 1);

    state_t             r_state;
    logic [MEL_AW-1:0]  r_j;
    logic [CEP_IW-1:0]  r_k;
    logic               r_busy;
    logic [CDCT_AW-1:0] r_cdct_cnt;
    logic [CDCT_AW-1:0] r_cdct_addr;
    logic [15:0]        r_regdct;
    logic [15:0]        r_cep_data;
    logic [CEP_IW-1:0]  r_cep_idx;
    logic               r_cep_valid;
    logic               r_done;

    logic               w_issue;
    logic               w_first;
    logic               w_last;
    logic               w_launch;
    logic               w_mel_valid;
    logic               w_mul_en;
    logic               w_acc_en;
    logic               w_acc_new;
    logic               w_cap;
    logic [CEP_IW-1:0]  w_cap_k;
    logic               w_empty;

    // A term is issued in every RUN cycle; r_j is both the mel address and the inner index.
    assign w_issue  = (r_state == ST_RUN);
    assign w_first  = (r_j == '0);
    assign w_last   = (r_j == J_LAST);
    assign w_launch = (r_state == ST_IDLE) && i_start;

    // Frame FSM: j inner / k outer loop in RUN, then wait for the term pipe to empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_j <= '0;
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_k <= r_k + CEP_IW'(1);
                        end
                    end else begin
                        r_j <= r_j + MEL_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ROM address counts terms linearly (k*NUM_FILT+j) and lags mel_addr by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdct_cnt  <= '0;
            r_cdct_addr <= '0;
        end else if (w_launch) begin
            r_cdct_cnt  <= '0;
        end else if (w_issue) begin
            r_cdct_addr <= r_cdct_cnt;
            r_cdct_cnt  <= r_cdct_cnt + CDCT_AW'(1);
        end
    end

    // Register the mel operand the cycle its read data is valid; holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regdct <= '0;
        end else if (w_mel_valid) begin
            r_regdct <= i_mel_rdata;
        end
    end

    // Capture the finished accumulator after the last term of each coefficient.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cep_data  <= '0;
            r_cep_idx   <= '0;
            r_cep_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cep_valid <= w_cap;
            r_done      <= w_cap && (w_cap_k == K_LAST);
            if (w_cap) begin
                r_cep_data <= i_addsubdct_out;
                r_cep_idx  <= w_cap_k;
            end
        end
    end

    dct_term_pipe u_term_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_issue     (w_issue),
        .i_first     (w_first),
        .i_last      (w_last),
        .i_k         (r_k),
        .o_mel_valid (w_mel_valid),
        .o_mul_en    (w_mul_en),
        .o_acc_en    (w_acc_en),
        .o_acc_new   (w_acc_new),
        .o_cap       (w_cap),
        .o_cap_k     (w_cap_k),
        .o_empty     (w_empty)
    );

    assign o_mel_addr      = r_j;
    assign o_cdct_addr     = r_cdct_addr;
    assign o_regdct_out    = r_regdct;
    assign o_muldct_en     = w_mul_en;
    assign o_addsubdct_en  = w_acc_en;
    assign o_addsubdct_new = w_acc_new;
    assign o_cep_data      = r_cep_data;
    assign o_cep_idx       = r_cep_idx;
    assign o_cep_valid     = r_cep_valid;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule

// File: tb/tb_dct_sequencer.sv
// tb/tb_dct_sequencer.sv - scoreboard bench for dct_sequencer with behavioural mel buffer, ROM and MAC
module tb_dct_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [4:0]  o_mel_addr;
    logic [15:0] i_mel_rdata;
    logic [8:0]  o_cdct_addr;
    logic [15:0] o_regdct_out;
    logic        o_muldct_en;
    logic        o_addsubdct_en;
    logic        o_addsubdct_new;
    logic [15:0] i_addsubdct_out;
    logic [15:0] o_cep_data;
    logic [3:0]  o_cep_idx;
    logic        o_cep_valid;
    logic        o_busy;
    logic        o_done;

    dct_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .o_mel_addr      (o_mel_addr),
        .i_mel_rdata     (i_mel_rdata),
        .o_cdct_addr     (o_cdct_addr),
        .o_regdct_out    (o_regdct_out),
        .o_muldct_en     (o_muldct_en),
        .o_addsubdct_en  (o_addsubdct_en),
        .o_addsubdct_new (o_addsubdct_new),
        .i_addsubdct_out (i_addsubdct_out),
        .o_cep_data      (o_cep_data),
        .o_cep_idx       (o_cep_idx),
        .o_cep_valid     (o_cep_valid),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    // Behavioural mel buffer, coefficient ROM and MAC.
    logic [15:0]        mel  [0:31];
    logic signed [15:0] coef [0:511];
    logic [15:0]        mel_q;
    logic signed [15:0] rom_q;
    logic signed [15:0] prod;
    logic [15:0]        acc;

    always @(posedge clk) begin
        mel_q <= mel[o_mel_addr];
        rom_q <= coef[o_cdct_addr];
        if (o_muldct_en) prod <= 16'($signed(o_regdct_out) * rom_q);
        if (o_addsubdct_en) acc <= o_addsubdct_new ? prod : acc + prod;
    end

    assign i_mel_rdata     = mel_q;
    assign i_addsubdct_out = acc;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
    } cep_t;
    cep_t sb_q[$];
    cep_t mon_e;

    // Frame timing tracker: d = cycles since the edge that sampled start.
    bit   track = 1'b0;
    int   trk_s = 0;
    int   d;
    int   err_addr, err_reg, err_en, err_ctl;
    int   mul_cnt, acc_cnt, new_cnt, cep_cnt, done_d;
    logic e_mul, e_acc, e_new, e_cv, e_busy, e_done;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every cep_valid, plus per-cycle timing expectations.
    always @(negedge clk) begin
        if (o_cep_valid) begin
            cep_cnt++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL cep_unexpected: idx %0d data %h with nothing expected", o_cep_idx, o_cep_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_cep_idx !== mon_e.idx || o_cep_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL cep_k%0d: got idx %0d data %h expected idx %0d data %h",
                             mon_e.idx, o_cep_idx, o_cep_data, mon_e.idx, mon_e.data);
                end
            end
        end
        if (track) begin
            d = edge_cnt - trk_s;
            if (d <= 337 && o_mel_addr !== 5'(d % 26)) err_addr++;
            if (d >= 1 && d <= 338 && o_cdct_addr !== 9'(d - 1)) err_addr++;
            if (d >= 2 && d <= 339 && o_regdct_out !== mel[(d - 2) % 26]) err_reg++;
            e_mul  = (d >= 2 && d <= 339);
            e_acc  = (d >= 3 && d <= 340);
            e_new  = e_acc && ((d - 3) % 26 == 0);
            e_cv   = (d >= 5 && d <= 342 && ((d - 5) % 26 == 25));
            e_busy = (d <= 342);
            e_done = (d == 342);
            if (o_muldct_en !== e_mul) err_en++;
            if (o_addsubdct_en !== e_acc) err_en++;
            if (o_addsubdct_new !== e_new) err_en++;
            if (o_cep_valid !== e_cv) err_ctl++;
            if (o_busy !== e_busy) err_ctl++;
            if (o_done !== e_done) err_ctl++;
            if (o_muldct_en) mul_cnt++;
            if (o_addsubdct_en) acc_cnt++;
            if (o_addsubdct_new) new_cnt++;
            if (o_done) done_d = d;
        end
    end

    task automatic load_ramp();
        for (int j = 0; j < 32; j++) mel[j] = (j < 26) ? 16'(j + 1) : 16'h0;
        for (int a = 0; a < 512; a++) coef[a] = 16'sd1;
    endtask

    task automatic load_signed();
        for (int j = 0; j < 32; j++) mel[j] = 16'h0100;
        for (int a = 0; a < 512; a++) coef[a] = (((a / 26) % 2) == 0) ? 16'sd1 : -16'sd1;
    endtask

    // kind 0: ramp (sum 1..26 = 351); kind 1: +/-26*256 alternating by k.
    task automatic push_exp(input int kind, input int n);
        cep_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = 4'(k);
            if (kind == 0) e.data = 16'd351;
            else e.data = (k % 2 == 0) ? 16'h1A00 : 16'hE600;
            sb_q.push_back(e);
        end
    endtask

    task automatic begin_frame();
        err_addr = 0; err_reg = 0; err_en = 0; err_ctl = 0;
        mul_cnt = 0; acc_cnt = 0; new_cnt = 0; cep_cnt = 0; done_d = -1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        trk_s = edge_cnt;
        track = 1'b1;
    endtask

    task automatic wait_d(input int target);
        while (edge_cnt - trk_s < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic end_frame(input string name, input int n_cep);
        track = 1'b0;
        check({name, "_addr_seq_errs"}, err_addr, 0);
        check({name, "_regdct_errs"}, err_reg, 0);
        check({name, "_enable_errs"}, err_en, 0);
        check({name, "_ctrl_timing_errs"}, err_ctl, 0);
        check({name, "_muldct_en_cycles"}, mul_cnt, 338);
        check({name, "_addsubdct_en_cycles"}, acc_cnt, 338);
        check({name, "_addsubdct_new_pulses"}, new_cnt, 13);
        check({name, "_cep_valid_count"}, cep_cnt, n_cep);
        check({name, "_done_offset"}, done_d, 342);
        check({name, "_scoreboard_left"}, sb_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_mel_addr"}, o_mel_addr, 0);
        check({name, "_cdct_addr"}, o_cdct_addr, 0);
        check({name, "_regdct_out"}, o_regdct_out, 0);
        check({name, "_muldct_en"}, o_muldct_en, 0);
        check({name, "_addsubdct_en"}, o_addsubdct_en, 0);
        check({name, "_addsubdct_new"}, o_addsubdct_new, 0);
        check({name, "_cep_data"}, o_cep_data, 0);
        check({name, "_cep_idx"}, o_cep_idx, 0);
        check({name, "_cep_valid"}, o_cep_valid, 0);
        check({name, "_busy"}, o_busy, 0);
        check({name, "_done"}, o_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        load_ramp();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp frame.
        load_ramp();
        push_exp(0, 13);
        begin_frame();
        wait_d(344);
        end_frame("ramp", 13);

        // Signed coefficients.
        load_signed();
        push_exp(1, 13);
        begin_frame();
        wait_d(344);
        end_frame("signed", 13);

        // start at cycles 5 and 343 ignored; start at cycle 345 launches a new frame.
        load_ramp();
        push_exp(0, 13);
        begin_frame();
        wait_d(4);
        pulse_start();
        wait_d(342);
        pulse_start();
        wait_d(344);
        end_frame("ignore", 13);
        push_exp(0, 13);
        begin_frame();
        wait_d(344);
        end_frame("second", 13);

        // Reset for one cycle at cycle 100 aborts the frame after k=0..2.
        push_exp(0, 3);
        begin_frame();
        wait_d(99);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        track = 1'b0;
        check_zero("midrst");
        check("midrst_addr_seq_errs", err_addr, 0);
        check("midrst_enable_errs", err_en, 0);
        check("midrst_ctrl_timing_errs", err_ctl, 0);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_cep_valid_count", cep_cnt, 3);
        check("midrst_scoreboard_left", sb_q.size(), 0);
        check("midrst_busy_after", o_busy, 0);

        // Full frame after reset.
        push_exp(0, 13);
        begin_frame();
        wait_d(344);
        end_frame("postrst", 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
